lc3_writeback_rf: RTL and testbench
===================================

Name: lc3_writeback_rf

Overview:
- LC-3 writeback stage: selects the writeback data source, writes the 8x16 general register file and updates the 3-bit condition-code register (PSR).
- Drives the vsr1, vsr2 and psr signals of the writeback_out bus. It is the responder end of the bus that the writeback_out agent monitors.
- Sits between execute/memaccess (data sources) and decode/execute (register read-back).

Parameters:
- DATA_W, 16, register and datapath width.
- NUM_REGS, 8, number of general registers; index width is clog2(NUM_REGS) = 3.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable_writeback  input  1  write-strobe for this cycle.
- W_Control  input  2  data select: 0=aluout, 1=pcout, 2=npc, 3=memout.
- aluout  input  16  execute result.
- pcout  input  16  computed PC/address result.
- npc  input  16  next PC (JSR link value).
- memout  input  16  memory read data.
- dr  input  3  destination register index.
- sr1  input  3  source register 1 read index.
- sr2  input  3  source register 2 read index.
- vsr1  output  16  contents of RF[sr1].
- vsr2  output  16  contents of RF[sr2].
- psr  output  3  condition codes {N,Z,P}.

Behaviour:
- Reset: reset=0 at any time, independent of clock.
  - All RF[0..7] cleared to 16'h0000 and psr cleared to 3'b000.
  - vsr1 and vsr2 read 16'h0000 while reset is held.
  - Reset asserted mid-write aborts the write; no partial update.
  - The first write accepted is on the first rising edge with reset=1.
- Data mux (combinational): wdata = aluout/pcout/npc/memout for W_Control 0/1/2/3.
- Write: on a rising edge with enable_writeback=1, RF[dr] <= wdata and psr is updated in the same edge.
  - psr = 3'b100 if wdata[15]=1.
  - psr = 3'b010 if wdata==0.
  - psr = 3'b001 otherwise (positive, nonzero).
  - With enable_writeback=0, RF and psr hold.
- Read: vsr1=RF[sr1], vsr2=RF[sr2], combinational from current register state.
  - Zero cycles from an sr change.
  - One cycle from the write edge: a written value appears on the cycle after the edge.
- No register is hardwired: R0 is writable.
- sr1==sr2 is legal; both outputs show the same value.
- Write to dr while sr1 and/or sr2 == dr in the same cycle: the outputs show the old value until the edge, unless the optional feature below is compiled in.
- Back-to-back writes every cycle are supported, with no bubble.
- psr is a flag register: it holds its last value across non-write cycles and is not recomputed from reads.
- X on W_Control or dr while enable_writeback=0 has no effect.

Optional Feature:
- Macro: LC3_WB_BYPASS_EN.
- Defined: same-cycle forwarding.
  - If enable_writeback=1 and sr1==dr, vsr1=wdata combinationally; vsr2 likewise for sr2.
  - psr output is unaffected; it still updates at the edge.
- Undefined: no forwarding; vsr1/vsr2 always reflect stored register contents.

Test Plan:
- Reset then read all regs:
  - Assert reset=0 mid-cycle → vsr1/vsr2 = 16'h0000 for sr1/sr2 = 0..7, psr = 3'b000, immediately without a clock edge.
- Source select:
  - Enable=1, dr=3, aluout=16'h1234, W_Control=0 → next cycle with sr1=3: vsr1=16'h1234, psr=3'b001.
  - Repeat with W_Control=3, memout=16'h8001, dr=5 → vsr2 (sr2=5) = 16'h8001, psr=3'b100.
- Zero flag and hold:
  - Write npc=16'h0000 via W_Control=2 to dr=0 → psr=3'b010, RF[0]=0.
  - Then 5 cycles with enable=0 and aluout=16'hFFFF → psr stays 3'b010 and RF unchanged.
- Back-to-back:
  - Writes R1=16'h0001, R2=16'hFFFE, R1=16'h7FFF on consecutive edges → after the third edge, sr1=1/sr2=2 give 16'h7FFF/16'hFFFE, psr=3'b001.
- Same-cycle hazard:
  - Enable=1, dr=sr1=4, RF[4]=16'h00AA, aluout=16'h0055 → before the edge, vsr1=16'h00AA without LC3_WB_BYPASS_EN and 16'h0055 with it.
  - After the edge, vsr1=16'h0055 in both builds.
- Reset mid-operation:
  - Assert reset between two write edges → all registers and psr = 0.
  - A write presented during reset is lost.
  - After release, the first write lands normally.

Source files
------------

// File: rtl/lc3_writeback_rf.sv
// LC-3 writeback stage: source mux, 8x16 register file and NZP condition-code register.
// Optional same-cycle write-to-read forwarding is compiled in with `define LC3_WB_BYPASS_EN.
module lc3_writeback_rf #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_writeback,
    input  logic [1:0]        W_Control,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] pcout,
    input  logic [DATA_W-1:0] npc,
    input  logic [DATA_W-1:0] memout,
    input  logic [IDX_W-1:0]  dr,
    input  logic [IDX_W-1:0]  sr1,
    input  logic [IDX_W-1:0]  sr2,
    output logic [DATA_W-1:0] vsr1,
    output logic [DATA_W-1:0] vsr2,
    output logic [2:0]        psr
);

    logic [DATA_W-1:0] r_rf [NUM_REGS];
    logic [2:0]        r_psr;
    logic [DATA_W-1:0] w_wdata;

    function automatic logic [2:0] f_nzp(input logic [DATA_W-1:0] v);
        if (v[DATA_W-1])
            return 3'b100;
        else if (v == '0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    always_comb begin
        case (W_Control)
            2'd0:    w_wdata = aluout;
            2'd1:    w_wdata = pcout;
            2'd2:    w_wdata = npc;
            default: w_wdata = memout;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_rf[i] <= '0;
            r_psr <= 3'b000;
        end else if (enable_writeback) begin
            r_rf[dr] <= w_wdata;
            r_psr    <= f_nzp(w_wdata);
        end
    end

    assign psr = r_psr;

`ifdef LC3_WB_BYPASS_EN
    // Forwarding is suppressed during reset so the outputs read zero while it is held.
    always_comb begin
        vsr1 = r_rf[sr1];
        vsr2 = r_rf[sr2];
        if (reset && enable_writeback && (sr1 == dr))
            vsr1 = w_wdata;
        if (reset && enable_writeback && (sr2 == dr))
            vsr2 = w_wdata;
    end
`else
    assign vsr1 = r_rf[sr1];
    assign vsr2 = r_rf[sr2];
`endif

endmodule

// File: tb/tb_lc3_writeback_rf.sv
// Directed self-checking bench for lc3_writeback_rf (default and LC3_WB_BYPASS_EN builds).
module tb_lc3_writeback_rf;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable_writeback = 1'b0;
    logic [1:0]  W_Control = 2'd0;
    logic [15:0] aluout = 16'h0, pcout = 16'h0, npc = 16'h0, memout = 16'h0;
    logic [2:0]  dr = 3'd0, sr1 = 3'd0, sr2 = 3'd0;
    logic [15:0] vsr1, vsr2;
    logic [2:0]  psr;

    int checks = 0;
    int errors = 0;

    lc3_writeback_rf dut (
        .clock(clock), .reset(reset), .enable_writeback(enable_writeback),
        .W_Control(W_Control), .aluout(aluout), .pcout(pcout), .npc(npc),
        .memout(memout), .dr(dr), .sr1(sr1), .sr2(sr2),
        .vsr1(vsr1), .vsr2(vsr2), .psr(psr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a write, let one rising edge take it, then drop the strobe.
    task automatic wr(input logic [1:0] sel, input logic [2:0] d, input logic [15:0] v);
        W_Control = sel;
        dr = d;
        case (sel)
            2'd0: aluout = v;
            2'd1: pcout  = v;
            2'd2: npc    = v;
            default: memout = v;
        endcase
        enable_writeback = 1'b1;
        @(posedge clock); #1;
        enable_writeback = 1'b0;
    endtask

    initial begin
        // Put some nonzero state in before the first reset.
        @(posedge clock); #1;
        wr(2'd1, 3'd7, 16'h1111);
        sr1 = 3'd7; #1;
        check("pre_reset_r7", vsr1, 16'h1111);
        check("pre_reset_psr", {13'd0, psr}, 16'h0001);

        // Reset asserted mid-cycle: immediate clear, no edge needed.
        #2 reset = 1'b0; #1;
        for (int i = 0; i < 8; i++) begin
            sr1 = i[2:0]; sr2 = 3'(7 - i); #1;
            check($sformatf("rst_vsr1_r%0d", i), vsr1, 16'h0000);
            check($sformatf("rst_vsr2_r%0d", 7 - i), vsr2, 16'h0000);
        end
        check("rst_psr", {13'd0, psr}, 16'h0000);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        // Source select: ALU to R3, then memory to R5.
        wr(2'd0, 3'd3, 16'h1234);
        sr1 = 3'd3; #1;
        check("alu_r3", vsr1, 16'h1234);
        check("alu_psr", {13'd0, psr}, 16'h0001);
        wr(2'd3, 3'd5, 16'h8001);
        sr2 = 3'd5; #1;
        check("mem_r5", vsr2, 16'h8001);
        check("mem_psr", {13'd0, psr}, 16'h0004);
        wr(2'd1, 3'd6, 16'h4000);
        sr1 = 3'd6; #1;
        check("pc_r6", vsr1, 16'h4000);

        // Zero flag via npc into R0, then hold with garbage on the inputs.
        wr(2'd0, 3'd0, 16'h0001);
        wr(2'd2, 3'd0, 16'h0000);
        sr1 = 3'd0; #1;
        check("npc_r0", vsr1, 16'h0000);
        check("zero_psr", {13'd0, psr}, 16'h0002);
        aluout = 16'hFFFF; W_Control = 2'bxx; dr = 3'bxxx;
        sr1 = 3'd0; sr2 = 3'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check($sformatf("hold_psr_%0d", i), {13'd0, psr}, 16'h0002);
            check($sformatf("hold_r0_%0d", i), vsr1, 16'h0000);
            check($sformatf("hold_r3_%0d", i), vsr2, 16'h1234);
        end
        sr2 = 3'd5; #1;
        check("hold_r5", vsr2, 16'h8001);

        // Back-to-back writes on consecutive edges.
        W_Control = 2'd0; enable_writeback = 1'b1;
        dr = 3'd1; aluout = 16'h0001;
        @(posedge clock); #1;
        dr = 3'd2; aluout = 16'hFFFE;
        @(posedge clock); #1;
        dr = 3'd1; aluout = 16'h7FFF;
        @(posedge clock); #1;
        enable_writeback = 1'b0;
        sr1 = 3'd1; sr2 = 3'd2; #1;
        check("b2b_r1", vsr1, 16'h7FFF);
        check("b2b_r2", vsr2, 16'hFFFE);
        check("b2b_psr", {13'd0, psr}, 16'h0001);

        // Same-cycle hazard on R4.
        wr(2'd0, 3'd4, 16'h00AA);
        W_Control = 2'd0; dr = 3'd4; sr1 = 3'd4; sr2 = 3'd2;
        aluout = 16'h0055; enable_writeback = 1'b1; #1;
`ifdef LC3_WB_BYPASS_EN
        check("haz_before", vsr1, 16'h0055);
`else
        check("haz_before", vsr1, 16'h00AA);
`endif
        check("haz_other", vsr2, 16'hFFFE);
        @(posedge clock); #1;
        enable_writeback = 1'b0; #1;
        check("haz_after", vsr1, 16'h0055);
        check("haz_psr", {13'd0, psr}, 16'h0001);

        // Reset between write edges; a write held during reset is lost.
        wr(2'd3, 3'd6, 16'hF0F0);
        @(negedge clock); #2;
        reset = 1'b0;
        W_Control = 2'd0; dr = 3'd6; aluout = 16'h2222; enable_writeback = 1'b1;
        sr1 = 3'd6; sr2 = 3'd4; #1;
        check("midrst_r6", vsr1, 16'h0000);
        check("midrst_r4", vsr2, 16'h0000);
        check("midrst_psr", {13'd0, psr}, 16'h0000);
        @(posedge clock); #1;
        enable_writeback = 1'b0;
        check("rst_write_lost", vsr1, 16'h0000);
        @(negedge clock);
        reset = 1'b1; #1;
        check("release_r6", vsr1, 16'h0000);
        check("release_psr", {13'd0, psr}, 16'h0000);
        wr(2'd1, 3'd6, 16'h0002);
        check("first_write_r6", vsr1, 16'h0002);
        check("first_write_psr", {13'd0, psr}, 16'h0001);
        sr2 = 3'd6; #1;
        check("same_sr_vsr2", vsr2, 16'h0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
